// File: rtl/aclk_alarm_sequencer_pkg.sv
// Shared types and constants for the alarm clock sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package aclk_pkg;

   localparam int SECS_PER_MIN = 60;

   // Wide enough for the longest snooze: 15 minutes of seconds.
   localparam int TIMER_W = $clog2(15 * 60 + 1);

   typedef struct packed {
      logic [3:0] h_tens;
      logic [3:0] h_units;
      logic [3:0] m_tens;
      logic [3:0] m_units;
   } bcd_time_t;

   typedef enum logic [1:0] {
      IDLE,
      RINGING,
      SNOOZE,
      LOCKOUT
   } state_t;

endpackage

// File: rtl/aclk_alarm_sequencer_if.sv
// Bundle of time/alarm inputs, button pulses and buzzer outputs for the sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; all inputs are pulses or levels, all outputs are registered levels/pulses.
// Ports: master drives time, enable and buttons and observes outputs; slave is the sequencer.
interface aclk_alarm_sequencer_if;
   import aclk_pkg::*;

   logic      one_second;
   logic      alarm_enable;
   bcd_time_t cur_time;
   bcd_time_t alarm_time;
   logic      snooze_btn;
   logic      stop_btn;
   logic      sound_alarm;
   logic      snoozing;
   logic [2:0] snooze_count;
   logic      alarm_done;

   modport master (
      output one_second, alarm_enable, cur_time, alarm_time, snooze_btn, stop_btn,
      input  sound_alarm, snoozing, snooze_count, alarm_done
   );

   modport slave (
      input  one_second, alarm_enable, cur_time, alarm_time, snooze_btn, stop_btn,
      output sound_alarm, snoozing, snooze_count, alarm_done
   );

endinterface

// File: rtl/aclk_alarm_sequencer_sec_timer.sv
// Loadable seconds down-counter; decrements on tick, holds at zero, never wraps.
// Latency: load takes effect next cycle; expire is combinational on the tick that takes 1 -> 0.
// Backpressure: none; load has priority over tick, so a tick coinciding with a load is dropped.
// Ports: clk/reset, tick (one_second), load/load_val, zero (count==0), expire (reaching-zero pulse).
module aclk_sec_timer #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         tick,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero,
   output logic         expire
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero   = (cnt_q == '0);
   // Independent of load so the controller can use it to decide whether to load.
   assign expire = tick && (cnt_q == W'(1));

endmodule

// File: rtl/aclk_alarm_sequencer.sv
// Alarm sequencer: rising-edge time match rings the buzzer, with snooze, stop, ring timeout and snooze limit.
// Latency: outputs are registered, one cycle after the causing input.
// Backpressure: none; button pulses and ticks are consumed in the cycle they arrive.
// Ports: clk, reset (sync, active-high); bus (slave) carries time/alarm/enable/buttons in and buzzer state out.
module aclk_alarm_sequencer
   import aclk_pkg::*;
#(
   parameter int SNOOZE_MIN     = 5,
   parameter int RING_TIMEOUT_S = 60,
   parameter int MAX_SNOOZES    = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   aclk_alarm_sequencer_if.slave bus
);

   localparam logic [TIMER_W-1:0] RING_LOAD   = TIMER_W'(RING_TIMEOUT_S);
   localparam logic [TIMER_W-1:0] SNOOZE_LOAD = TIMER_W'(SNOOZE_MIN * SECS_PER_MIN);
   localparam logic [2:0]         MAX_CNT     = 3'(MAX_SNOOZES);

   state_t       state_q, state_d;
   logic         match, match_q, trigger;
   logic         sound_alarm_q, snoozing_q, alarm_done_q;
   logic [2:0]   snooze_count_q, snooze_count_d;
   logic         done_d;
   logic         tmr_load;
   logic [TIMER_W-1:0] tmr_load_val;
   logic         tmr_zero, tmr_expire, tmr_fire;

   assign match   = (bus.cur_time == bus.alarm_time);
   // Edge-only so a stopped alarm cannot re-ring during the same minute.
   assign trigger = match && !match_q && bus.alarm_enable;

   aclk_sec_timer #(.W(TIMER_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .tick     (bus.one_second),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .zero     (tmr_zero),
      .expire   (tmr_expire)
   );

   // A timer already sitting at zero while active also counts as expiry on a
   // tick, so the FSM can never stall in RINGING/SNOOZE.
   assign tmr_fire = tmr_expire || (tmr_zero && bus.one_second);

   always_comb begin
      state_d        = state_q;
      snooze_count_d = snooze_count_q;
      done_d         = 1'b0;
      tmr_load       = 1'b0;
      tmr_load_val   = RING_LOAD;

      if (!bus.alarm_enable) begin
         state_d        = IDLE;
         snooze_count_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (trigger) begin
                  state_d        = RINGING;
                  tmr_load       = 1'b1;
                  tmr_load_val   = RING_LOAD;
                  snooze_count_d = '0;
               end
            end
            RINGING: begin
               if (bus.stop_btn) begin
                  state_d = LOCKOUT;
                  done_d  = 1'b1;
               end else if (bus.snooze_btn || tmr_fire) begin
                  if (snooze_count_q < MAX_CNT) begin
                     state_d        = SNOOZE;
                     tmr_load       = 1'b1;
                     tmr_load_val   = SNOOZE_LOAD;
                     snooze_count_d = snooze_count_q + 3'd1;
                  end else begin
                     // Snoozes exhausted: a snooze request ends the event.
                     state_d = LOCKOUT;
                     done_d  = 1'b1;
                  end
               end
            end
            SNOOZE: begin
               if (bus.stop_btn) begin
                  state_d = LOCKOUT;
                  done_d  = 1'b1;
               end else if (tmr_fire) begin
                  state_d      = RINGING;
                  tmr_load     = 1'b1;
                  tmr_load_val = RING_LOAD;
               end
            end
            LOCKOUT: begin
               // Wait out the matching minute; the count stays visible until then.
               if (!match) begin
                  state_d        = IDLE;
                  snooze_count_d = '0;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         match_q        <= 1'b0;
         sound_alarm_q  <= 1'b0;
         snoozing_q     <= 1'b0;
         snooze_count_q <= '0;
         alarm_done_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         match_q        <= match;
         sound_alarm_q  <= (state_d == RINGING);
         snoozing_q     <= (state_d == SNOOZE);
         snooze_count_q <= snooze_count_d;
         alarm_done_q   <= done_d;
      end
   end

   assign bus.sound_alarm  = sound_alarm_q;
   assign bus.snoozing     = snoozing_q;
   assign bus.snooze_count = snooze_count_q;
   assign bus.alarm_done   = alarm_done_q;

endmodule

// File: tb/tb_aclk_alarm_sequencer.sv
// Self-checking bench for aclk_alarm_sequencer: queue of expected outputs per driven cycle.
// Latency: expectations are compared one clock after the stimulus they belong to.
// Backpressure: n/a.
module tb_aclk_alarm_sequencer;
   import aclk_pkg::*;

   localparam int SM = 1;
   localparam int RT = 5;
   localparam int MS = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   aclk_alarm_sequencer_if bus();

   aclk_alarm_sequencer #(
      .SNOOZE_MIN     (SM),
      .RING_TIMEOUT_S (RT),
      .MAX_SNOOZES    (MS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic       snd;
      logic       snz;
      logic [2:0] cnt;
      logic       done;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];
   int    n_chk = 0;
   int    n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
   endtask

   // Drive one cycle of pulses, queue what the outputs must be after the edge,
   // then pop and compare once the edge has passed.
   task automatic step(input logic sec, input logic snz, input logic stp,
                       input logic e_snd, input logic e_sz, input int e_cnt,
                       input logic e_done, input string tag);
      exp_t  e;
      exp_t  g;
      string t;
      @(negedge clk);
      bus.one_second = sec;
      bus.snooze_btn = snz;
      bus.stop_btn   = stp;
      e.snd  = e_snd;
      e.snz  = e_sz;
      e.cnt  = 3'(e_cnt);
      e.done = e_done;
      sb_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      bus.one_second = 1'b0;
      bus.snooze_btn = 1'b0;
      bus.stop_btn   = 1'b0;
      g = sb_q.pop_front();
      t = tag_q.pop_front();
      check({t, ".sound"},  32'(bus.sound_alarm),  32'(g.snd));
      check({t, ".snooze"}, 32'(bus.snoozing),     32'(g.snz));
      check({t, ".count"},  32'(bus.snooze_count), 32'(g.cnt));
      check({t, ".done"},   32'(bus.alarm_done),   32'(g.done));
   endtask

   task automatic ticks(input int n, input logic e_snd, input logic e_sz,
                        input int e_cnt, input string tag);
      for (int i = 0; i < n; i++) begin
         step(1'b1, 1'b0, 1'b0, e_snd, e_sz, e_cnt, 1'b0, tag);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.one_second   = 1'b0;
      bus.snooze_btn   = 1'b0;
      bus.stop_btn     = 1'b0;
      bus.alarm_enable = 1'b1;
      bus.alarm_time   = 16'h0730;
      bus.cur_time     = 16'h0729;
      reset            = 1'b1;
      repeat (3) @(posedge clk);

      // Reset state
      step(0, 0, 0, 0, 0, 0, 0, "rst");
      check("rst.state", 32'(dut.state_q), 32'(IDLE));
      reset = 1'b0;

      // Basic trigger and stop
      step(0, 0, 0, 0, 0, 0, 0, "pre");
      bus.cur_time = 16'h0730;
      step(0, 0, 0, 1, 0, 0, 0, "trig");
      step(0, 0, 1, 0, 0, 0, 1, "stop");
      step(0, 0, 0, 0, 0, 0, 0, "lock");
      check("lock.state", 32'(dut.state_q), 32'(LOCKOUT));
      bus.cur_time = 16'h0731;
      step(0, 0, 0, 0, 0, 0, 0, "unlock");
      check("unlock.state", 32'(dut.state_q), 32'(IDLE));

      // Snooze cycle: 60 ticks of snooze then ring again
      bus.cur_time = 16'h0730;
      step(0, 0, 0, 1, 0, 0, 0, "t2trig");
      step(0, 1, 0, 0, 1, 1, 0, "t2snz");
      ticks(59, 0, 1, 1, "t2sz");
      step(1, 0, 0, 1, 0, 1, 0, "t2ring");
      step(0, 0, 1, 0, 0, 1, 1, "t2stop");
      bus.cur_time = 16'h0731;
      step(0, 0, 0, 0, 0, 0, 0, "t2idle");

      // Exhaustion: auto-snooze three times, fourth timeout ends the event
      bus.cur_time = 16'h0730;
      step(0, 0, 0, 1, 0, 0, 0, "t3trig");
      for (int k = 0; k <= MS; k++) begin
         ticks(RT - 1, 1, 0, k, "t3ring");
         if (k < MS) begin
            step(1, 0, 0, 0, 1, k + 1, 0, "t3auto");
            ticks(SM * 60 - 1, 0, 1, k + 1, "t3sz");
            step(1, 0, 0, 1, 0, k + 1, 0, "t3rering");
         end else begin
            step(1, 0, 0, 0, 0, MS, 1, "t3exhaust");
         end
      end
      step(0, 0, 0, 0, 0, MS, 0, "t3lock");
      check("t3lock.state", 32'(dut.state_q), 32'(LOCKOUT));
      bus.cur_time = 16'h0731;
      step(0, 0, 0, 0, 0, 0, 0, "t3idle");

      // Tick coinciding with snooze; snooze ignored while snoozing; stop beats snooze
      bus.cur_time = 16'h0730;
      step(0, 0, 0, 1, 0, 0, 0, "t4trig");
      ticks(RT - 1, 1, 0, 0, "t4ring");
      step(1, 1, 0, 0, 1, 1, 0, "t4tick_snz");
      step(0, 1, 0, 0, 1, 1, 0, "t4snz_ign");
      ticks(SM * 60 - 1, 0, 1, 1, "t4sz");
      step(1, 0, 0, 1, 0, 1, 0, "t4ring2");
      step(0, 1, 1, 0, 0, 1, 1, "t4both");
      step(0, 0, 0, 0, 0, 1, 0, "t4after");
      bus.cur_time = 16'h0731;
      step(0, 0, 0, 0, 0, 0, 0, "t4idle");

      // Disable while snoozing, then no retrigger on a held match
      bus.cur_time = 16'h0730;
      step(0, 0, 0, 1, 0, 0, 0, "t5trig");
      step(0, 1, 0, 0, 1, 1, 0, "t5snz");
      bus.alarm_enable = 1'b0;
      step(0, 0, 0, 0, 0, 0, 0, "t5dis");
      step(1, 0, 0, 0, 0, 0, 0, "t5dis2");
      bus.alarm_enable = 1'b1;
      step(0, 0, 0, 0, 0, 0, 0, "t5noretrig");
      step(1, 0, 0, 0, 0, 0, 0, "t5noretrig2");
      bus.cur_time = 16'h0731;
      step(0, 0, 0, 0, 0, 0, 0, "t5away");
      bus.cur_time = 16'h0730;
      step(0, 0, 0, 1, 0, 0, 0, "t5retrig");

      // Reset mid-ring, then a fresh match edge rings normally
      reset        = 1'b1;
      bus.cur_time = 16'h0731;
      step(0, 0, 0, 0, 0, 0, 0, "t6rst");
      check("t6rst.state", 32'(dut.state_q), 32'(IDLE));
      reset = 1'b0;
      step(0, 0, 0, 0, 0, 0, 0, "t6quiet");
      bus.cur_time = 16'h0730;
      step(0, 0, 0, 1, 0, 0, 0, "t6trig");
      step(0, 0, 1, 0, 0, 0, 1, "t6stop");
      step(0, 0, 0, 0, 0, 0, 0, "t6lock");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
